// File: rtl/uart_pkg.sv
// uart_pkg: state encoding, parity modes and oversampling constants shared by the UART transmitter and receiver
package uart_pkg;

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} tx_state_t;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    localparam int OVERSAMPLE  = 16;
    localparam int SAMPLE_LAST = OVERSAMPLE - 1;

    function automatic logic parity_bit(input logic [7:0] d, input int mode);
        return (mode == PAR_ODD) ? ~^d : (mode == PAR_EVEN) ? ^d : 1'b1;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: circular holding FIFO between the byte handshake and the serialiser
module uart_tx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      count;

    // DEPTH is a power of two, so the count MSB alone marks full
    assign full  = count[AW];
    assign empty = count == '0;
    assign dout  = mem[rd_ptr];

    always_ff @(posedge clk)
        if (push) mem[wr_ptr] <= din;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop) count <= count + (AW+1)'(1);
            else if (pop && !push) count <= count - (AW+1)'(1);
        end
    end

endmodule

// File: rtl/uart_tx.sv
// uart_tx: FIFO-buffered UART serialiser (start, LSB-first data, optional parity, stop) on a 16x clk_en tick
module uart_tx
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clk_en,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx,
    output logic                 tx_busy,
    output logic                 tx_done
);
    localparam int SW = $clog2(OVERSAMPLE);

    tx_state_t            state, state_nx;
    logic [SW-1:0]        sample, sample_nx;
    logic [2:0]           index, index_nx;
    logic [DATA_BITS-1:0] shift, shift_nx, fifo_dout;
    logic                 par, par_nx, tx_nx, done_nx;
    logic                 push, pop, full, empty, bit_end;

    assign push     = tx_valid && !full;
    assign tx_ready = !full;
    assign tx_busy  = state != S_IDLE || !empty;
    assign bit_end  = clk_en && sample == SW'(SAMPLE_LAST);

    uart_tx_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk(clk),
        .rst(rst),
        .push(push),
        .pop(pop),
        .din(tx_data),
        .dout(fifo_dout),
        .full(full),
        .empty(empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            sample  <= '0;
            index   <= '0;
            shift   <= '0;
            par     <= 1'b0;
            tx      <= 1'b1;
            tx_done <= 1'b0;
        end else begin
            state   <= state_nx;
            sample  <= sample_nx;
            index   <= index_nx;
            shift   <= shift_nx;
            par     <= par_nx;
            tx      <= tx_nx;
            tx_done <= done_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        sample_nx = (state != S_IDLE && clk_en) ? sample + SW'(1) : sample;
        index_nx  = index;
        shift_nx  = shift;
        par_nx    = par;
        done_nx   = 1'b0;
        case (state)
            S_START:  if (bit_end) state_nx = S_DATA;
            S_DATA: if (bit_end) begin
                shift_nx = shift >> 1;
                index_nx = index + 3'd1;
                if (index == 3'(DATA_BITS - 1)) begin
                    state_nx = (PARITY == PAR_NONE) ? S_STOP : S_PARITY;
                    index_nx = '0;
                end
            end
            S_PARITY: if (bit_end) state_nx = S_STOP;
            S_STOP: if (bit_end) begin
                index_nx = index + 3'd1;
                if (index == 3'(STOP_BITS - 1)) begin
                    done_nx  = 1'b1;
                    index_nx = '0;
                    state_nx = S_IDLE;
                end
            end
            default: ;
        endcase
        // Loading from IDLE or straight off the last stop bit gives back-to-back frames with no idle bit
        pop = (state == S_IDLE || done_nx) && !empty;
        if (pop) begin
            state_nx  = S_START;
            shift_nx  = fifo_dout;
            par_nx    = parity_bit(8'(fifo_dout), PARITY);
            sample_nx = '0;
            index_nx  = '0;
        end
        tx_nx = (state_nx == S_START) ? 1'b0 :
                (state_nx == S_DATA) ? shift_nx[0] :
                (state_nx == S_PARITY) ? par_nx : 1'b1;
    end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: four uart_tx configurations (8N1, 8E1, 8O1, 8N2) checked every cycle against a frame-level model
module tb_uart_tx;
    localparam int N = 4;

    logic       clk = 1'b0, rst = 1'b1, clk_en = 1'b1;
    logic [7:0] tx_data [N];
    logic       tx_valid [N], tx_ready [N], tx [N], tx_busy [N], tx_done [N];
    int         checks = 0, errors = 0, en_mode = 0, en_ph = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        uart_tx #(
            .DATA_BITS(8),
            .PARITY(g == 1 ? 1 : g == 2 ? 2 : 0),
            .STOP_BITS(g == 3 ? 2 : 1),
            .FIFO_DEPTH(4)
        ) u_dut (
            .clk(clk),
            .rst(rst),
            .clk_en(clk_en),
            .tx_data(tx_data[g]),
            .tx_valid(tx_valid[g]),
            .tx_ready(tx_ready[g]),
            .tx(tx[g]),
            .tx_busy(tx_busy[g]),
            .tx_done(tx_done[g])
        );
    end

    function automatic int par_of(int i);
        return i == 1 ? 1 : i == 2 ? 2 : 0;
    endfunction

    function automatic int stop_of(int i);
        return i == 3 ? 2 : 1;
    endfunction

    function automatic int nbits(int i);
        return 9 + (par_of(i) != 0 ? 1 : 0) + stop_of(i);
    endfunction

    // Whole frame as a bit list, index 0 first on the line; unused upper bits read as idle/stop
    function automatic logic [11:0] frame_of(int i, logic [7:0] d);
        logic [11:0] f;
        f = '1;
        f[0] = 1'b0;
        f[8:1] = d;
        if (par_of(i) != 0) f[9] = (par_of(i) == 1) ? ^d : ~^d;
        return f;
    endfunction

    task automatic chk(input string name, input int i, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 50) $display("FAIL %s[%0d] at %0t: got %b, expected %b", name, i, $time, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // Model: a queue of accepted bytes plus a frame in flight measured in clk_en pulses
    logic [7:0]  mq [N][8];
    int          mn [N], mcnt [N];
    logic        mact [N], mdone [N], m_acc;
    logic [11:0] fb [N];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                mn[i] = 0;
                mcnt[i] = 0;
                mact[i] = 1'b0;
                mdone[i] = 1'b0;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                m_acc = tx_valid[i] && mn[i] < 4;
                mdone[i] = 1'b0;
                if (mact[i] && clk_en) begin
                    mcnt[i]++;
                    if (mcnt[i] == 16 * nbits(i)) begin
                        mdone[i] = 1'b1;
                        mact[i] = 1'b0;
                    end
                end
                if (!mact[i] && mn[i] > 0) begin
                    fb[i] = frame_of(i, mq[i][0]);
                    mcnt[i] = 0;
                    mact[i] = 1'b1;
                    for (int k = 0; k < 7; k++) mq[i][k] = mq[i][k + 1];
                    mn[i]--;
                end
                if (m_acc) begin
                    mq[i][mn[i]] = tx_data[i];
                    mn[i]++;
                end
            end
        end
    end

    logic e_tx, e_rdy, e_busy, e_done;

    always @(negedge clk) begin
        for (int i = 0; i < N; i++) begin
            e_tx   = rst ? 1'b1 : mact[i] ? fb[i][mcnt[i] / 16] : 1'b1;
            e_rdy  = rst || mn[i] < 4;
            e_busy = !rst && (mact[i] || mn[i] > 0);
            e_done = !rst && mdone[i];
            chk("tx", i, tx[i], e_tx);
            chk("tx_ready", i, tx_ready[i], e_rdy);
            chk("tx_busy", i, tx_busy[i], e_busy);
            chk("tx_done", i, tx_done[i], e_done);
        end
    end

    always @(negedge clk) begin
        en_ph = (en_ph + 1) % 3;
        clk_en = en_mode == 0 ? 1'b1 : en_mode == 1 ? (en_ph == 0) : 1'($urandom_range(0, 1));
    end

    logic [11:0] pat [N];

    // One frame per selected instance, with mid-bit samples checked against hand-written bit patterns
    task automatic run_frame(input logic [3:0] mask, input int bitlen);
        @(negedge clk);
        for (int i = 0; i < N; i++) tx_valid[i] = mask[i];
        @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < N; i++) tx_valid[i] = 1'b0;
        for (int t = 1; t <= 12 * bitlen; t++) begin
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
                if (mask[i]) begin
                    if (t == 1) chk("start_fall", i, tx[i], 1'b0);
                    if ((t - 1) % bitlen == bitlen / 2 && (t - 1) / bitlen < nbits(i))
                        chk("mid_bit", i, tx[i], pat[i][(t - 1) / bitlen]);
                    if (bitlen == 16 && (t == 16 * nbits(i) || t == 16 * nbits(i) + 2))
                        chk("done_quiet", i, tx_done[i], 1'b0);
                    if (bitlen == 16 && t == 16 * nbits(i) + 1) begin
                        chk("done_pulse", i, tx_done[i], 1'b1);
                        chk("busy_drop", i, tx_busy[i], 1'b0);
                    end
                end
            end
        end
    endtask

    time first_t, sixth_t;

    initial begin
        for (int i = 0; i < N; i++) begin
            tx_valid[i] = 1'b0;
            tx_data[i] = 8'h00;
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rst_tx", 0, tx[0], 1'b1);
        chk("rst_ready", 0, tx_ready[0], 1'b1);
        chk("rst_busy", 0, tx_busy[0], 1'b0);
        chk("rst_done", 0, tx_done[0], 1'b0);
        @(negedge clk);
        rst = 1'b0;

        tx_data[0] = 8'hA5;
        tx_data[1] = 8'h07;
        tx_data[2] = 8'h07;
        tx_data[3] = 8'hFF;
        pat[0] = {3'b111, 8'hA5, 1'b0};
        pat[1] = {2'b11, 1'b1, 8'h07, 1'b0};
        pat[2] = {2'b11, 1'b0, 8'h07, 1'b0};
        pat[3] = {1'b1, 2'b11, 8'hFF, 1'b0};
        run_frame(4'b1111, 16);
        en_mode = 1;
        run_frame(4'b1111, 48);
        en_mode = 0;
        repeat (4) @(negedge clk);

        for (int k = 1; k <= 6; k++) begin
            int w;
            w = 0;
            @(negedge clk);
            tx_valid[0] = 1'b1;
            tx_data[0] = 8'(k);
            if (k == 6) chk("full_stall", 0, tx_ready[0], 1'b0);
            while (!tx_ready[0] && w < 400) begin
                @(negedge clk);
                w++;
            end
            if (w == 400) begin
                checks++;
                errors++;
                $display("FAIL ready_timeout at %0t: tx_ready never returned", $time);
            end
            @(posedge clk);
            if (k == 1) first_t = $time;
            if (k == 6) sixth_t = $time;
        end
        @(negedge clk);
        tx_valid[0] = 1'b0;
        chk_int("stall_edges", int'((sixth_t - first_t) / 10), 162);
        repeat (1100) @(negedge clk);
        chk("fifo_drained", 0, tx_busy[0], 1'b0);

        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            tx_valid[0] = 1'b1;
            tx_data[0] = 8'(8'h11 * (k + 1));
        end
        @(negedge clk);
        tx_valid[0] = 1'b0;
        repeat (40) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midframe_rst_tx", 0, tx[0], 1'b1);
        chk("midframe_rst_ready", 0, tx_ready[0], 1'b1);
        chk("midframe_rst_busy", 0, tx_busy[0], 1'b0);
        chk("midframe_rst_done", 0, tx_done[0], 1'b0);
        @(negedge clk);
        rst = 1'b0;
        tx_data[0] = 8'h3C;
        pat[0] = {3'b111, 8'h3C, 1'b0};
        run_frame(4'b0001, 16);

        en_mode = 2;
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                tx_valid[i] = ($urandom % 16) == 0;
                tx_data[i] = 8'($urandom);
            end
        end
        @(negedge clk);
        for (int i = 0; i < N; i++) tx_valid[i] = 1'b0;
        repeat (3000) @(negedge clk);
        for (int i = 0; i < N; i++) chk("final_idle", i, tx_busy[i], 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
